branch_history_table: RTL and testbench
=======================================

// Module: branch_history_table
// PURPOSE
// - Dynamic branch predictor sitting directly upstream of instruction fetch; drives the fetch stage's predicted_x70.
// - Fetch presents the PC of each issued instruction.
// - One cycle later the block returns a taken/not-taken prediction from a table of 2-bit saturating counters.
// - Execute reports resolved branches back to train the table; the block also keeps lookup and mispredict statistics.
// PARAMETERS
// - ENTRIES     64     number of table entries; power of 2, >= 4
// - IDX_W       6      log2(ENTRIES); index = PC[IDX_W+1:2] (byte PC, word aligned)
// - INIT_STATE  2'b01  counter value after reset (weakly not-taken)
// - CNT_W       16     width of each statistics counter
// PORTS
// - clk_x70                in   1      single clock; all state changes on its rising edge
// - rst_x70                in   1      asynchronous, active-high reset
// - lookup_valid_x70       in   1      fetch presents a PC this cycle
// - lookup_pc_x70          in   32     PC being fetched
// - predicted_x70          out  1      registered prediction for the previous cycle's lookup (1 = taken)
// - predict_valid_x70      out  1      predicted_x70 corresponds to a lookup made last cycle
// - update_valid_x70       in   1      execute resolved a branch this cycle
// - update_pc_x70          in   32     PC of the resolved branch
// - update_taken_x70       in   1      actual outcome (1 = taken)
// - update_mispredict_x70  in   1      execute's prediction for this branch was wrong
// - lookup_count_x70       out  CNT_W  number of accepted lookups, saturating
// - mispredict_count_x70   out  CNT_W  number of updates with mispredict set, saturating
// BEHAVIOUR
// - Reset (asynchronous, takes effect immediately, mid-cycle included):
//   - every table entry = INIT_STATE;
//   - predicted_x70 = 0, predict_valid_x70 = 0;
//   - both statistics counters = 0; global history = 0.
// - Counter FSM per entry: SNT=00, WNT=01, WT=10, ST=11.
//   - Taken increments, saturating at ST; not-taken decrements, saturating at SNT.
//   - Prediction = counter[1].
// - Lookup, 1-cycle latency:
//   - lookup_valid=1 at edge N -> predicted_x70 and predict_valid_x70=1 after edge N.
//   - lookup_valid=0 -> predict_valid_x70=0 and predicted_x70 holds its last value.
// - Update: on update_valid=1 the indexed counter moves one FSM step at the edge. update_taken and update_mispredict are ignored when update_valid=0.
// - Simultaneous lookup and update, same index: read-before-write. The lookup returns the pre-update counter; the update still applies.
// - Aliasing: PCs with equal index bits share an entry; there are no tags.
// - Statistics:
//   - lookup_count increments on every lookup_valid.
//   - mispredict_count increments on update_valid & update_mispredict.
//   - Both hold at 2^CNT_W-1 and never wrap.
// CONFIGURATION
// - Macro BHT_GSHARE_EN.
// - Defined:
//   - an IDX_W-bit global history register (GHR) shifts in update_taken on each update_valid (non-speculative, no repair needed);
//   - both lookup and update index = PC[IDX_W+1:2] ^ GHR;
//   - a same-cycle lookup uses the GHR value from before that cycle's shift.
// - Undefined: no GHR is instantiated; index = PC[IDX_W+1:2].
// STRUCTURE
// - Shared header bp_defs.vh holds the constants:
//   - counter state encodings SNT/WNT/WT/ST;
//   - the default INIT_STATE;
//   - index-extraction macro.
// - One sub-module, bp_sat_counter (CNT_W-bit saturating event counter with async reset), instantiated twice for the statistics.
// - Table, index logic and GHR stay in this module.
// TESTING
// - Reset, then lookup PC 0x40 -> next cycle predicted=0, predict_valid=1, lookup_count=1.
// - Two taken updates at 0x40 -> lookup gives 1; a third taken keeps ST.
//   - Then one not-taken -> still 1 (WT); a second not-taken -> 0 (WNT).
// - Same cycle: lookup 0x40 while a taken update hits 0x40 (entry at WT).
//   - The lookup returns 1 (pre-update).
//   - The following lookup returns 1 (now ST).
// - Aliasing, ENTRIES=64: two taken updates at 0x140 -> lookup at 0x40 returns 1 (both map to index 0x10).
// - Statistics, CNT_W=4:
//   - 20 lookups -> lookup_count=15;
//   - 3 updates with mispredict=1 plus 2 with update_valid=0 and mispredict=1 -> mispredict_count=3.
// - Assert rst_x70 between edges mid-stream:
//   - outputs go to 0 without a clock edge;
//   - after release, every PC predicts 0 (WNT).
// - With BHT_GSHARE_EN: one taken update at PC 0x0 (GHR=1).
//   - Then two taken updates at 0x4: first at GHR=1 -> index 0; second at GHR=3 -> index 2.
//   - Lookup 0x0 now (GHR=7) reads index 7, not yet trained -> 0.

Source files
------------

// File: rtl/branch_history_table_pkg.sv
// Shared constants for the branch predictor: counter state encodings, default
// reset state and the PC bit where the table index starts.
package branch_history_table_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_state_e;

  localparam logic [1:0] BP_INIT_STATE = WNT;
  // PCs are word aligned, so the two lowest bits carry no index information
  localparam int unsigned BP_PC_LSB = 2;

  // One FSM step of a 2-bit saturating counter
  function automatic logic [1:0] bp_step(input logic [1:0] state, input logic taken);
    logic [1:0] next_state;
    next_state = state;
    if (taken && state != ST) begin
      next_state = state + 2'd1;
    end else if (!taken && state != SNT) begin
      next_state = state - 2'd1;
    end
    return next_state;
  endfunction

endpackage

// File: rtl/branch_history_table_sat_counter.sv
// CNT_W-bit event counter that sticks at all-ones instead of wrapping.
module bp_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && r_count != {CNT_W{1'b1}}) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/branch_history_table.sv
// Bimodal branch predictor (2-bit counters, 1-cycle lookup) with statistics.
// Defining BHT_GSHARE_EN folds a global history register into the index (gshare).
module branch_history_table
  import branch_history_table_pkg::*;
#(
  parameter int         ENTRIES    = 64,
  parameter int         IDX_W      = 6,
  parameter logic [1:0] INIT_STATE = BP_INIT_STATE,
  parameter int         CNT_W      = 16
) (
  input  logic             clk_x70,
  input  logic             rst_x70,
  input  logic             lookup_valid_x70,
  input  logic [31:0]      lookup_pc_x70,
  output logic             predicted_x70,
  output logic             predict_valid_x70,
  input  logic             update_valid_x70,
  input  logic [31:0]      update_pc_x70,
  input  logic             update_taken_x70,
  input  logic             update_mispredict_x70,
  output logic [CNT_W-1:0] lookup_count_x70,
  output logic [CNT_W-1:0] mispredict_count_x70
);

  logic [1:0]       r_table [ENTRIES];
  logic             r_predicted;
  logic             r_predict_valid;
  logic [IDX_W-1:0] w_lookup_idx;
  logic [IDX_W-1:0] w_update_idx;
  logic             w_unused_pc_bits;

`ifdef BHT_GSHARE_EN
  logic [IDX_W-1:0] r_ghr;

  // History is trained only by resolved branches, so it never needs repair
  always_ff @(posedge clk_x70 or posedge rst_x70) begin
    if (rst_x70) begin
      r_ghr <= '0;
    end else if (update_valid_x70) begin
      r_ghr <= {r_ghr[IDX_W-2:0], update_taken_x70};
    end
  end

  assign w_lookup_idx = lookup_pc_x70[IDX_W+BP_PC_LSB-1:BP_PC_LSB] ^ r_ghr;
  assign w_update_idx = update_pc_x70[IDX_W+BP_PC_LSB-1:BP_PC_LSB] ^ r_ghr;
`else
  assign w_lookup_idx = lookup_pc_x70[IDX_W+BP_PC_LSB-1:BP_PC_LSB];
  assign w_update_idx = update_pc_x70[IDX_W+BP_PC_LSB-1:BP_PC_LSB];
`endif

  assign w_unused_pc_bits = ^{lookup_pc_x70[31:IDX_W+BP_PC_LSB], lookup_pc_x70[BP_PC_LSB-1:0],
                              update_pc_x70[31:IDX_W+BP_PC_LSB], update_pc_x70[BP_PC_LSB-1:0]};

  always_ff @(posedge clk_x70 or posedge rst_x70) begin
    if (rst_x70) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i] <= INIT_STATE;
      end
    end else if (update_valid_x70) begin
      r_table[w_update_idx] <= bp_step(r_table[w_update_idx], update_taken_x70);
    end
  end

  // Reads the table as it stood before this edge's update (read-before-write)
  always_ff @(posedge clk_x70 or posedge rst_x70) begin
    if (rst_x70) begin
      r_predicted     <= 1'b0;
      r_predict_valid <= 1'b0;
    end else begin
      r_predict_valid <= lookup_valid_x70;
      if (lookup_valid_x70) begin
        r_predicted <= r_table[w_lookup_idx][1];
      end
    end
  end

  assign predicted_x70     = r_predicted;
  assign predict_valid_x70 = r_predict_valid;

  bp_sat_counter #(.CNT_W(CNT_W)) u_lookup_cnt (
    .clk     (clk_x70),
    .rst     (rst_x70),
    .i_inc   (lookup_valid_x70),
    .o_count (lookup_count_x70)
  );

  bp_sat_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
    .clk     (clk_x70),
    .rst     (rst_x70),
    .i_inc   (update_valid_x70 & update_mispredict_x70),
    .o_count (mispredict_count_x70)
  );

endmodule

// File: tb/tb_branch_history_table.sv
// Randomized and directed checks of branch_history_table against a table-of-integers model.
module tb_branch_history_table;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = 15;

  logic             clk_x70 = 1'b0;
  logic             rst_x70;
  logic             lookup_valid_x70;
  logic [31:0]      lookup_pc_x70;
  logic             predicted_x70;
  logic             predict_valid_x70;
  logic             update_valid_x70;
  logic [31:0]      update_pc_x70;
  logic             update_taken_x70;
  logic             update_mispredict_x70;
  logic [CNT_W-1:0] lookup_count_x70;
  logic [CNT_W-1:0] mispredict_count_x70;

  int total = 0;
  int bad = 0;

  // Model: counter strength 0..3 per entry, prediction = strength >= 2
  int m_tbl [64];
  int m_ghr;
  int m_lc;
  int m_mc;
  bit exp_pred;
  bit exp_valid;

  always #5 clk_x70 = ~clk_x70;

  branch_history_table #(.CNT_W(CNT_W)) dut (
    .clk_x70               (clk_x70),
    .rst_x70               (rst_x70),
    .lookup_valid_x70      (lookup_valid_x70),
    .lookup_pc_x70         (lookup_pc_x70),
    .predicted_x70         (predicted_x70),
    .predict_valid_x70     (predict_valid_x70),
    .update_valid_x70      (update_valid_x70),
    .update_pc_x70         (update_pc_x70),
    .update_taken_x70      (update_taken_x70),
    .update_mispredict_x70 (update_mispredict_x70),
    .lookup_count_x70      (lookup_count_x70),
    .mispredict_count_x70  (mispredict_count_x70)
  );

  function automatic int m_idx(input logic [31:0] pc);
    int idx;
    idx = int'((pc >> 2) % 64);
`ifdef BHT_GSHARE_EN
    idx = idx ^ m_ghr;
`endif
    return idx;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) m_tbl[i] = 1;
    m_ghr = 0;
    m_lc = 0;
    m_mc = 0;
    exp_pred = 0;
    exp_valid = 0;
  endfunction

  // Drives one cycle of stimulus from between edges and advances the model.
  task automatic do_cycle(input bit lv, input logic [31:0] lpc, input bit uv,
                          input logic [31:0] upc, input bit ut, input bit um);
    int li;
    int ui;
    lookup_valid_x70 = lv;
    lookup_pc_x70 = lpc;
    update_valid_x70 = uv;
    update_pc_x70 = upc;
    update_taken_x70 = ut;
    update_mispredict_x70 = um;
    @(posedge clk_x70);
    li = m_idx(lpc);
    ui = m_idx(upc);
    exp_valid = lv;
    if (lv) begin
      exp_pred = (m_tbl[li] >= 2);
      if (m_lc < CNT_MAX) m_lc++;
    end
    if (uv) begin
      if (ut) m_tbl[ui] = (m_tbl[ui] < 3) ? m_tbl[ui] + 1 : 3;
      else    m_tbl[ui] = (m_tbl[ui] > 0) ? m_tbl[ui] - 1 : 0;
      if (um && m_mc < CNT_MAX) m_mc++;
      m_ghr = ((m_ghr << 1) | int'(ut)) % 64;
    end
    #1;
    lookup_valid_x70 = 0;
    update_valid_x70 = 0;
  endtask

  task automatic apply_reset();
    rst_x70 = 1;
    #1;
    rst_x70 = 0;
    m_reset();
  endtask

  task automatic test_reset();
    rst_x70 = 1;
    lookup_valid_x70 = 0; lookup_pc_x70 = 0;
    update_valid_x70 = 0; update_pc_x70 = 0;
    update_taken_x70 = 0; update_mispredict_x70 = 0;
    m_reset();
    #2;
    total++;
    if (predicted_x70 !== 1'b0 || predict_valid_x70 !== 1'b0 ||
        lookup_count_x70 !== 4'd0 || mispredict_count_x70 !== 4'd0) begin
      bad++;
      $display("FAIL reset: pred=%b valid=%b lc=%0d mc=%0d, want all 0",
               predicted_x70, predict_valid_x70, lookup_count_x70, mispredict_count_x70);
    end
    @(negedge clk_x70);
    rst_x70 = 0;
    @(posedge clk_x70); #1;
  endtask

  task automatic test_first_lookup();
    do_cycle(1, 32'h40, 0, 0, 0, 0);
    total++;
    if (predicted_x70 !== 1'b0 || predict_valid_x70 !== 1'b1 || lookup_count_x70 !== 4'd1) begin
      bad++;
      $display("FAIL first_lookup: pred=%b valid=%b lc=%0d, want 0 1 1",
               predicted_x70, predict_valid_x70, lookup_count_x70);
    end
    do_cycle(0, 32'h40, 0, 0, 0, 0);
    total++;
    if (predict_valid_x70 !== 1'b0 || predicted_x70 !== exp_pred) begin
      bad++;
      $display("FAIL idle_hold: pred=%b valid=%b, want %b 0", predicted_x70, predict_valid_x70, exp_pred);
    end
  endtask

  task automatic test_training();
    bit want [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bit dir [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_cycle(0, 0, 1, 32'h40, 1, 0);
    for (int s = 0; s < 4; s++) begin
      do_cycle(0, 0, 1, 32'h40, dir[s], 0);
      do_cycle(1, 32'h40, 0, 0, 0, 0);
      total++;
      if (predicted_x70 !== exp_pred || predict_valid_x70 !== 1'b1) begin
        bad++;
        $display("FAIL training step%0d: pred=%b valid=%b, want %b 1", s, predicted_x70, predict_valid_x70, exp_pred);
      end
`ifndef BHT_GSHARE_EN
      total++;
      if (predicted_x70 !== want[s]) begin
        bad++;
        $display("FAIL training_const step%0d: pred=%b, want %b", s, predicted_x70, want[s]);
      end
`endif
    end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    do_cycle(0, 0, 1, 32'h40, 1, 0);
    do_cycle(1, 32'h40, 1, 32'h40, 1, 0);
    total++;
    if (predicted_x70 !== exp_pred || predict_valid_x70 !== 1'b1) begin
      bad++;
      $display("FAIL same_cycle_pre: pred=%b valid=%b, want %b 1", predicted_x70, predict_valid_x70, exp_pred);
    end
    do_cycle(1, 32'h40, 0, 0, 0, 0);
    total++;
    if (predicted_x70 !== exp_pred) begin
      bad++;
      $display("FAIL same_cycle_post: pred=%b, want %b", predicted_x70, exp_pred);
    end
`ifndef BHT_GSHARE_EN
    total++;
    if (predicted_x70 !== 1'b1) begin
      bad++;
      $display("FAIL same_cycle_const: pred=%b, want 1", predicted_x70);
    end
`endif
  endtask

  task automatic test_alias();
    apply_reset();
    do_cycle(0, 0, 1, 32'h140, 1, 0);
    do_cycle(0, 0, 1, 32'h140, 1, 0);
    do_cycle(1, 32'h40, 0, 0, 0, 0);
    total++;
    if (predicted_x70 !== exp_pred) begin
      bad++;
      $display("FAIL alias: pred=%b, want %b", predicted_x70, exp_pred);
    end
`ifndef BHT_GSHARE_EN
    total++;
    if (predicted_x70 !== 1'b1) begin
      bad++;
      $display("FAIL alias_const: pred=%b, want 1", predicted_x70);
    end
`endif
  endtask

  task automatic test_stats();
    apply_reset();
    for (int i = 0; i < 20; i++) do_cycle(1, $urandom, 0, 0, 0, 0);
    total++;
    if (lookup_count_x70 !== 4'd15) begin
      bad++;
      $display("FAIL lookup_sat: lc=%0d, want 15", lookup_count_x70);
    end
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 1, $urandom, 1'($urandom), 1);
    for (int i = 0; i < 2; i++) do_cycle(0, 0, 0, $urandom, 1'($urandom), 1);
    total++;
    if (mispredict_count_x70 !== 4'd3) begin
      bad++;
      $display("FAIL mispredict_count: mc=%0d, want 3", mispredict_count_x70);
    end
    for (int i = 0; i < 20; i++) do_cycle(0, 0, 1, $urandom, 1'($urandom), 1);
    total++;
    if (mispredict_count_x70 !== 4'(m_mc) || m_mc != CNT_MAX) begin
      bad++;
      $display("FAIL mispredict_sat: mc=%0d, want %0d", mispredict_count_x70, m_mc);
    end
  endtask

  task automatic test_random();
    logic [31:0] pcs [4] = '{32'h40, 32'h140, 32'h44, 32'h80};
    logic [31:0] lpc;
    logic [31:0] upc;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      lpc = ($urandom_range(0, 3) == 0) ? $urandom : pcs[$urandom_range(0, 3)];
      upc = ($urandom_range(0, 3) == 0) ? $urandom : pcs[$urandom_range(0, 3)];
      do_cycle(($urandom_range(0, 3) != 0), lpc, 1'($urandom), upc, 1'($urandom), 1'($urandom));
      total++;
      if (predicted_x70 !== exp_pred || predict_valid_x70 !== exp_valid ||
          lookup_count_x70 !== 4'(m_lc) || mispredict_count_x70 !== 4'(m_mc)) begin
        bad++;
        $display("FAIL random cyc%0d: pred=%b valid=%b lc=%0d mc=%0d, want %b %b %0d %0d", i,
                 predicted_x70, predict_valid_x70, lookup_count_x70, mispredict_count_x70,
                 exp_pred, exp_valid, m_lc, m_mc);
      end
    end
  endtask

  task automatic test_async_reset();
    do_cycle(0, 0, 1, 32'h40, 1, 1);
    do_cycle(0, 0, 1, 32'h40, 1, 1);
    do_cycle(0, 0, 1, 32'h40, 1, 1);
    do_cycle(1, 32'h40, 0, 0, 0, 0);
    #2;
    rst_x70 = 1;
    m_reset();
    #1;
    total++;
    if (predicted_x70 !== 1'b0 || predict_valid_x70 !== 1'b0 ||
        lookup_count_x70 !== 4'd0 || mispredict_count_x70 !== 4'd0) begin
      bad++;
      $display("FAIL async_reset: pred=%b valid=%b lc=%0d mc=%0d, want all 0",
               predicted_x70, predict_valid_x70, lookup_count_x70, mispredict_count_x70);
    end
    #3;
    rst_x70 = 0;
    for (int i = 0; i < 16; i++) begin
      do_cycle(1, $urandom, 0, 0, 0, 0);
      total++;
      if (predicted_x70 !== 1'b0 || predict_valid_x70 !== 1'b1) begin
        bad++;
        $display("FAIL post_reset_wnt #%0d: pred=%b valid=%b, want 0 1", i, predicted_x70, predict_valid_x70);
      end
    end
  endtask

`ifdef BHT_GSHARE_EN
  task automatic test_gshare();
    apply_reset();
    do_cycle(0, 0, 1, 32'h0, 1, 0);
    do_cycle(0, 0, 1, 32'h4, 1, 0);
    do_cycle(0, 0, 1, 32'h4, 1, 0);
    do_cycle(1, 32'h0, 0, 0, 0, 0);
    total++;
    if (predicted_x70 !== 1'b0 || predicted_x70 !== exp_pred) begin
      bad++;
      $display("FAIL gshare_idx7: pred=%b, want 0", predicted_x70);
    end
    do_cycle(1, 32'h14, 0, 0, 0, 0);
    total++;
    if (predicted_x70 !== 1'b1) begin
      bad++;
      $display("FAIL gshare_idx2: pred=%b, want 1", predicted_x70);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_lookup();
    test_training();
    test_same_cycle();
    test_alias();
    test_stats();
    test_random();
    test_async_reset();
`ifdef BHT_GSHARE_EN
    test_gshare();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
